// File: rtl/vc_rcache.sv
// Direct-mapped, write-through, no-write-allocate read cache in front of the 8-bit bus bridge.
// Optional flush input is compiled in with `define VC_RCACHE_FLUSH_EN.
module vc_rcache #(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef VC_RCACHE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [14:0] c_raddr,
    input  logic [1:0]  c_rreq,
    output logic [15:0] c_rdata,
    output logic        c_rdone,
    input  logic [14:0] c_waddr,
    input  logic [1:0]  c_wmask,
    input  logic [15:0] c_wdata,
    output logic        c_wdone,
    output logic [14:0] m_raddr,
    output logic [1:0]  m_rreq,
    input  logic [15:0] m_rdata,
    input  logic        m_rdone,
    output logic [14:0] m_waddr,
    output logic [15:0] m_wdata,
    output logic [1:0]  m_wmask,
    input  logic        m_wdone
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 15 - IW;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    state_t             state_r;
    logic [ENTRIES-1:0] valid_r;
    logic [TW-1:0]      tag_r  [ENTRIES];
    logic [15:0]        data_r [ENTRIES];

    logic [IW-1:0] rd_idx_s;
    logic [IW-1:0] fill_idx_s;
    logic [IW-1:0] wr_idx_s;
    logic          rd_hit_s;
    logic          wr_hit_s;
    logic          fill_we_s;
    logic          merge_we_s;
    logic          flush_now_s;

`ifdef VC_RCACHE_FLUSH_EN
    logic flush_pend_r;

    // Pending flush request; a new flush pulse wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_r <= 1'b0;
        end else if (flush) begin
            flush_pend_r <= 1'b1;
        end else if (flush_now_s) begin
            flush_pend_r <= 1'b0;
        end
    end
`endif

    // Lookup and storage-update decode; fill and merge addresses come from the held bridge registers.
    always_comb begin
        rd_idx_s   = c_raddr[IW-1:0];
        fill_idx_s = m_raddr[IW-1:0];
        wr_idx_s   = m_waddr[IW-1:0];
        rd_hit_s   = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == c_raddr[14:IW]);
        wr_hit_s   = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == m_waddr[14:IW]);
        fill_we_s  = (state_r == FILL) && m_rdone;
        merge_we_s = (state_r == WRITE) && m_wdone && wr_hit_s;
`ifdef VC_RCACHE_FLUSH_EN
        flush_now_s = (state_r == IDLE) && flush_pend_r;
`else
        flush_now_s = 1'b0;
`endif
    end

    // Tag and data arrays; only the valid bits need a reset.
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            tag_r[fill_idx_s]  <= m_raddr[14:IW];
            data_r[fill_idx_s] <= m_rdata;
        end else if (merge_we_s) begin
            if (m_wmask[0]) begin
                data_r[wr_idx_s][7:0] <= m_wdata[7:0];
            end
            if (m_wmask[1]) begin
                data_r[wr_idx_s][15:8] <= m_wdata[15:8];
            end
        end
    end

    // Controller: arbitration, bridge handshakes, completion pulses and valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            valid_r <= {ENTRIES{1'b0}};
            c_rdata <= 16'h0000;
            c_rdone <= 1'b0;
            c_wdone <= 1'b0;
            m_raddr <= 15'h0000;
            m_rreq  <= 2'b00;
            m_waddr <= 15'h0000;
            m_wdata <= 16'h0000;
            m_wmask <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush_now_s) begin
                        valid_r <= {ENTRIES{1'b0}};
                    end else if (|c_wmask) begin
                        m_waddr <= c_waddr;
                        m_wdata <= c_wdata;
                        m_wmask <= c_wmask;
                        state_r <= WRITE;
                    end else if (|c_rreq) begin
                        if (rd_hit_s) begin
                            c_rdata <= data_r[rd_idx_s];
                            c_rdone <= 1'b1;
                            state_r <= RESP;
                        end else begin
                            m_raddr <= c_raddr;
                            m_rreq  <= 2'b11;
                            state_r <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (m_rdone) begin
                        m_rreq              <= 2'b00;
                        valid_r[fill_idx_s] <= 1'b1;
                        c_rdata             <= m_rdata;
                        c_rdone             <= 1'b1;
                        state_r             <= RESP;
                    end
                end
                WRITE: begin
                    if (m_wdone) begin
                        m_wmask <= 2'b00;
                        c_wdone <= 1'b1;
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    c_rdone <= 1'b0;
                    c_wdone <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/vc_rcache.md
# vc_rcache

Direct-mapped, write-through, no-write-allocate read cache between the CPU memory port and the 8-bit external-bus bridge. Read hits return in one cycle without touching the external bus. Misses fetch a full 16-bit word through the bridge. CPU writes are forwarded unchanged and update any cached copy.

## Interface
Parameters:
- ENTRIES, 8, number of 16-bit lines; power of two, 2..64. IW = log2(ENTRIES).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- c_raddr  in  15  CPU read word address [15:1]
- c_rreq  in  2  CPU read byte-lane request; nonzero = request; held until c_rdone
- c_rdata  out  16  read data, full word, valid while c_rdone=1
- c_rdone  out  1  one-cycle read completion pulse
- c_waddr  in  15  CPU write word address [15:1]
- c_wmask  in  2  CPU write byte mask; nonzero = request; held until c_wdone
- c_wdata  in  16  CPU write data
- c_wdone  out  1  one-cycle write completion pulse
- m_raddr  out  15  bridge read address
- m_rreq  out  2  bridge read request; always 2'b11 or 2'b00
- m_rdata  in  16  bridge read data, valid with m_rdone
- m_rdone  in  1  bridge read completion pulse
- m_waddr, m_wdata, m_wmask  out  15/16/2  bridge write request, copied from CPU
- m_wdone  in  1  bridge write completion pulse

## Operation
- Line index = addr[IW:1]; tag = addr[15:IW+1]; per-line valid bit.
- States: IDLE, FILL, WRITE, RESP.
- IDLE arbitration:
  - Flush pending (if compiled in) has top priority.
  - Then |c_wmask wins over |c_rreq, matching bridge priority.
  - Then read.
- Read hit in IDLE:
  - Next edge loads c_rdata from the line, pulses c_rdone, and enters RESP.
  - c_rreq lanes do not affect hit/miss; a valid tag match is a hit.
- Read miss in IDLE:
  - Next edge loads m_raddr = c_raddr, sets m_rreq = 2'b11, and enters FILL.
- FILL:
  - Hold m_raddr and m_rreq until m_rdone=1 is sampled.
  - On that edge: m_rreq <= 0; line <= {valid, tag, m_rdata}; c_rdata <= m_rdata; c_rdone <= 1; enter RESP.
- WRITE:
  - Entered from IDLE with m_waddr/m_wdata/m_wmask registered from CPU inputs; these are held until m_wdone.
  - On the m_wdone edge: m_wmask <= 0; c_wdone <= 1; enter RESP.
  - On the same edge, if the line is valid with a matching tag, merge bytes (mask[0] updates [7:0], mask[1] updates [15:8]).
  - A write miss leaves the cache untouched.
- RESP:
  - Lasts one cycle; done pulses drop and the state returns to IDLE.
  - No request is sampled in RESP, so a requester may drop or change its request in the cycle its done is high.
- m_rdone/m_wdone outside FILL/WRITE are ignored.

## Timing
- Reset values: c_rdata=0, c_rdone=0, c_wdone=0, m_raddr=0, m_rreq=0, m_waddr=0, m_wdata=0, m_wmask=0, all valid=0, state IDLE.
- Read hit: request seen in IDLE at cycle T; c_rdone=1 at T+1; next request sampled at T+2.
- Read miss: m_rreq=2'b11 from T+1; c_rdone=1 one cycle after the m_rdone cycle.
- Write: m_wmask valid from T+1; c_wdone=1 one cycle after the m_wdone cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-FILL/WRITE: everything clears immediately and the in-flight bridge transaction is abandoned. The bridge is reset by the same rst_n, so its own reset covers the abandoned transfer.
- Wrap: address 15'h7fff maps to the last index with no special case.

## Configuration
- VC_RCACHE_FLUSH_EN defined:
  - Adds input `flush` (1 bit).
  - A high cycle sets a pending flag, which is also settable during FILL/WRITE.
  - The next IDLE cycle clears all valid bits and the pending flag, and accepts no request that cycle.
  - Requests resume on the following cycle.
- VC_RCACHE_FLUSH_EN undefined: no `flush` port; valid bits clear only on reset.

## Test plan
- Cold read c_raddr=15'h0123 → m_rreq=2'b11 at m_raddr=15'h0123. Bridge returns 16'hBEEF → c_rdata=16'hBEEF with one c_rdone pulse.
- Repeat read of 15'h0123 → c_rdone at T+1, m_rreq stays 0.
- Write 15'h0123, mask 2'b01, data 16'h0055 → forwarded to m_*, c_wdone pulses. The next read of 15'h0123 returns 16'hBE55 with no bus read.
- Aliasing (ENTRIES=8): 15'h0001 then 15'h0009 both miss. A re-read of 15'h0001 misses again.
- Simultaneous c_wmask=2'b11 and c_rreq=2'b11 in IDLE → write completes first, then the read.
- Assert rst_n=0 mid-FILL → m_rreq=0 immediately. After release, the same read misses. With the flush macro on, flush after a fill forces the next read to miss.
